// File: rtl/result_readout_seq.sv
// Result readout sequencer: waits for all cores to finish, then streams
// NUM_WORDS result words from the array memory over a valid/ready port.
module result_readout_seq #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int NUM_WORDS = 512,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              end_process1,
  input  logic              end_process2,
  input  logic              end_process3,
  input  logic              end_process4,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    ISSUE,
    WAIT_RD,
    PUSH,
    FINISH
  } state_t;

  localparam logic [ADDR_W:0] LAST =
    (ADDR_W+1)'(NUM_WORDS - 1);
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [2:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic all_done;
  logic run_st;
  logic hs;

  assign all_done = end_process1 & end_process2 &
                    end_process3 & end_process4;
  assign run_st   = (state_q == ISSUE) ||
                    (state_q == WAIT_RD) ||
                    (state_q == PUSH);
  assign hs       = valid_q & out_ready;

  assign addr      = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a core dropping its flag mid-run overrides all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (all_done) state_d = ISSUE;
      end
      ISSUE: begin
        addr_d  = cnt_q[ADDR_W-1:0];
        lat_d   = LAT_INIT;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (lat_q == 3'd0) begin
          data_d  = result;
          valid_d = 1'b1;
          state_d = PUSH;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      PUSH: begin
        if (hs) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // An accepted word in the abort cycle still counts (cnt_d kept)
    if (run_st && !all_done) begin
      state_d = IDLE;
      err_d   = 1'b1;
      valid_d = 1'b0;
      done_d  = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      lat_d   = '0;
    end
  end

endmodule

// File: tb/tb_result_readout_seq.sv
// Bench for result_readout_seq: three instances (RD_LAT 2, 1, 7)
// share stimulus and are checked against a timeline model.
module tb_result_readout_seq;

  localparam int AW = 12;
  localparam int DW = 12;
  localparam int NW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] fl = 4'hF;

  logic [2:0][AW-1:0] addr_a;
  logic [2:0][DW-1:0] res_a;
  logic [2:0][DW-1:0] data_a;
  logic [2:0] valid_a;
  logic [2:0] busy_a;
  logic [2:0] done_a;
  logic [2:0] err_a;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 1 : ((g == 2) ? 7 : 2);
    logic [AW-1:0] dly [7];

    // Memory model: data appears RD_LAT edges after addr
    always @(posedge clk) begin
      dly[0] <= addr_a[g];
      for (int j = 1; j < 7; j++) dly[j] <= dly[j-1];
    end

    assign res_a[g] = dly[LAT-1] + DW'(100);

    result_readout_seq #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .NUM_WORDS(NW),
      .RD_LAT(LAT)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .end_process1(fl[0]),
      .end_process2(fl[1]),
      .end_process3(fl[2]),
      .end_process4(fl[3]),
      .addr(addr_a[g]),
      .result(res_a[g]),
      .out_data(data_a[g]),
      .out_valid(valid_a[g]),
      .out_ready(out_ready),
      .busy(busy_a[g]),
      .done(done_a[g]),
      .err(err_a[g])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, int i, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d",
               nm, i, act, exp);
    end
  endtask

  function automatic int lat_of(int i);
    return (i == 1) ? 1 : ((i == 2) ? 7 : 2);
  endfunction

  // model: phase 0 idle, 1 waiting for cores, 2 streaming, 3 done
  int ph [3];
  int kk [3];
  int t_addr [3];
  int t_val [3];
  int e_addr [3];
  int e_data [3];
  bit e_valid [3];
  bit e_err [3];
  bit e_done [3];
  int tc = 0;

  int hs_n [3];
  int done_n [3];
  int last_hs [3];
  int first_dat [3];
  int last_dat [3];
  int sp_first [3];
  int sp_bad [3];

  task automatic clr_stats();
    for (int i = 0; i < 3; i++) begin
      hs_n[i] = 0;
      done_n[i] = 0;
      sp_first[i] = 0;
      sp_bad[i] = 0;
      first_dat[i] = -1;
      last_dat[i] = -1;
    end
  endtask

  // Compare current outputs, then predict state after next edge
  initial begin
    int ne;
    bit hs;
    bit all;
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; kk[i] = 0; e_addr[i] = 0; e_data[i] = 0;
      e_valid[i] = 0; e_err[i] = 0; e_done[i] = 0;
      t_addr[i] = -1; t_val[i] = -1;
    end
    clr_stats();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("valid", i, int'(valid_a[i]), int'(e_valid[i]));
        chk("busy", i, int'(busy_a[i]), int'(ph[i] != 0));
        chk("done", i, int'(done_a[i]), int'(e_done[i]));
        chk("err", i, int'(err_a[i]), int'(e_err[i]));
        chk("addr", i, int'(addr_a[i]), e_addr[i]);
        if (e_valid[i])
          chk("data", i, int'(data_a[i]), e_data[i]);
      end
      ne = tc + 1;
      for (int i = 0; i < 3; i++) begin
        if (rst_n && valid_a[i] && out_ready) begin
          if (hs_n[i] == 0) first_dat[i] = int'(data_a[i]);
          else if (hs_n[i] == 1) sp_first[i] = ne - last_hs[i];
          else if (ne - last_hs[i] != sp_first[i]) sp_bad[i]++;
          last_hs[i] = ne;
          last_dat[i] = int'(data_a[i]);
          hs_n[i]++;
        end
        if (done_a[i]) done_n[i]++;
      end
      all = &fl;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          ph[i] = 0; kk[i] = 0; e_addr[i] = 0; e_data[i] = 0;
          e_valid[i] = 0; e_err[i] = 0; e_done[i] = 0;
        end else begin
          case (ph[i])
            0: begin
              e_done[i] = 0;
              if (start) begin
                ph[i] = 1; kk[i] = 0; e_err[i] = 0;
              end
            end
            1: begin
              if (all) begin
                ph[i] = 2;
                t_addr[i] = ne + 1;
                t_val[i] = ne + lat_of(i) + 2;
              end
            end
            2: begin
              hs = e_valid[i] && out_ready;
              if (!all) begin
                ph[i] = 0; e_err[i] = 1; e_valid[i] = 0;
              end else if (hs) begin
                e_valid[i] = 0;
                if (kk[i] == NW - 1) begin
                  ph[i] = 3; e_done[i] = 1;
                end else begin
                  kk[i]++;
                  t_addr[i] = ne + 1;
                  t_val[i] = ne + lat_of(i) + 2;
                end
              end else begin
                if (ne == t_addr[i]) e_addr[i] = kk[i];
                if (ne == t_val[i]) begin
                  e_valid[i] = 1;
                  e_data[i] = (kk[i] + 100) % (1 << DW);
                end
              end
            end
            default: begin
              e_done[i] = 0; ph[i] = 0;
            end
          endcase
        end
      end
      tc = ne;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(int rnd);
    int n = 0;
    do begin
      if (rnd == 1) out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
      n++;
    end while (busy_a != 3'b000 && n < 20000);
    chk("idle_timeout", 0, int'(n < 20000), 1);
  endtask

  // Directed scenarios with randomized back-pressure
  initial begin
    int n;
    int bad;
    bit s3;
    bit s7;
    rst_n = 1'b0;
    cyc(3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_data", i, int'(data_a[i]), 0);
      chk("rst_addr", i, int'(addr_a[i]), 0);
    end
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // full run, ready always high
    clr_stats();
    out_ready = 1'b1;
    pulse_start();
    wait_idle(0);
    cyc(2);
    chk("r1_words", 0, hs_n[0], 512);
    chk("r1_first", 0, first_dat[0], 100);
    chk("r1_last", 0, last_dat[0], 611);
    chk("r1_addr", 0, int'(addr_a[0]), 511);
    chk("r1_sp", 0, sp_first[0], 5);
    chk("r1_sp", 1, sp_first[1], 4);
    chk("r1_sp", 2, sp_first[2], 10);
    for (int i = 0; i < 3; i++) begin
      chk("r1_done_n", i, done_n[i], 1);
      chk("r1_sp_bad", i, sp_bad[i], 0);
      chk("r1_err", i, int'(err_a[i]), 0);
    end

    // reset while a word is held in PUSH
    clr_stats();
    out_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!valid_a[0] && n < 100) begin
      cyc(1);
      n++;
    end
    chk("push_timeout", 0, int'(n < 100), 1);
    rst_n = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("mrst_valid", 0, int'(valid_a[0]), 0);
    chk("mrst_busy", 0, int'(busy_a[0]), 0);
    chk("mrst_addr", 0, int'(addr_a[0]), 0);
    chk("mrst_data", 0, int'(data_a[0]), 0);
    chk("mrst_done", 0, int'(done_a[0]), 0);
    chk("mrst_err", 0, int'(err_a[0]), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // core 4 late by 50 cycles, random back-pressure
    clr_stats();
    fl = 4'b0111;
    pulse_start();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
      if (addr_a[0] != '0 || !busy_a[0] || valid_a[0]) bad++;
    end
    chk("r2_hold_bad", 0, bad, 0);
    fl = 4'hF;
    wait_idle(1);
    cyc(2);
    chk("r2_last", 0, last_dat[0], 611);
    for (int i = 0; i < 3; i++) begin
      chk("r2_words", i, hs_n[i], 512);
      chk("r2_done_n", i, done_n[i], 1);
      chk("r2_err", i, int'(err_a[i]), 0);
    end

    // core 2 drops after word 10; stray starts mid-run
    clr_stats();
    pulse_start();
    n = 0;
    s3 = 0;
    s7 = 0;
    while (hs_n[0] < 11 && n < 20000) begin
      start = 1'b0;
      if (hs_n[0] == 3 && !s3) begin start = 1'b1; s3 = 1; end
      if (hs_n[0] == 7 && !s7) begin start = 1'b1; s7 = 1; end
      out_ready = ($urandom_range(0, 1) != 0);
      cyc(1);
      n++;
    end
    start = 1'b0;
    chk("r3_timeout", 0, int'(n < 20000), 1);
    fl = 4'b1101;
    wait_idle(1);
    cyc(2);
    chk("r3_words", 0, hs_n[0], 11);
    for (int i = 0; i < 3; i++) begin
      chk("r3_err", i, int'(err_a[i]), 1);
      chk("r3_done_n", i, done_n[i], 0);
    end

    // next accepted start clears err
    fl = 4'hF;
    out_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    chk("err_clr", 0, int'(err_a[0]), 0);
    cyc(1);
    rst_n = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
